// File: rtl/qoi_chunk_decoder.sv
// qoi_chunk_decoder: streaming QOI chunk decoder (chunk bytes after the 14-byte header).
//   clk, rst_n          clock, async active-low reset
//   i_start, i_npix     frame start pulse and pixel count (sampled on i_start)
//   s_data/s_valid/s_ready   chunk byte input stream
//   m_pixel/m_valid/m_ready  decoded pixel output {a,b,g,r}
//   o_busy, o_done, o_err    frame in progress, frame complete, run overshoot (sticky)
module qoi_chunk_decoder #(
  parameter int unsigned SIZE_W    = 30,
  parameter int unsigned CHANNELS  = 4,
  parameter logic [7:0]  ALPHA_DEF = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [SIZE_W-1:0] i_npix,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       m_pixel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_COLLECT, S_LUMA2, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       prev_q, prev_d, pix_q, pix_d;
  logic [63:0]       vld_q, vld_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [5:0]        run_q, run_d;
  logic [1:0]        col_q, col_d;
  logic              rgba_q, rgba_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        dg_q, dg_d;
  logic              mval_q, mval_d, err_q, err_d;

  logic [31:0] mem [64];
  logic        issue, slot_free, hs, last_out, can_issue, acc;
  logic [31:0] new_pix, emit_pix, idx_rd;
  logic [5:0]  wr_idx;
  logic [7:0]  nr, ng, nb;

  function automatic logic [5:0] hash6(input logic [31:0] p);
    logic [7:0] s;
    s = p[7:0] * 8'd3 + p[15:8] * 8'd5 + p[23:16] * 8'd7 + p[31:24] * 8'd11;
    return s[5:0];
  endfunction

  always_comb begin
    slot_free = !mval_q || m_ready;
    hs        = mval_q && m_ready;
    // The pixel currently held is the frame's last one: stop pulling bytes / run pixels.
    last_out  = mval_q && (cnt_q == SIZE_W'(1));
    can_issue = slot_free && !last_out;
    s_ready   = (state_q == S_OP || state_q == S_COLLECT || state_q == S_LUMA2) && can_issue;
    acc       = s_valid && s_ready;
    idx_rd    = vld_q[s_data[5:0]] ? mem[s_data[5:0]] : '0;
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pix_d   = pix_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    col_d   = col_q;
    rgba_d  = rgba_q;
    buf_d   = buf_q;
    dg_d    = dg_q;
    mval_d  = mval_q;
    err_d   = err_q;
    issue   = 1'b0;
    new_pix = '0;
    nr      = '0;
    ng      = '0;
    nb      = '0;

    if (hs) begin
      cnt_d  = cnt_q - SIZE_W'(1);
      mval_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          prev_d  = {ALPHA_DEF, 24'h0};
          vld_d   = '0;
          cnt_d   = i_npix;
          run_d   = '0;
          err_d   = 1'b0;
          mval_d  = 1'b0;
          state_d = (i_npix == '0) ? S_DONE : S_OP;
        end
      end
      S_OP: begin
        if (acc) begin
          if (s_data == 8'hFE || s_data == 8'hFF) begin
            rgba_d  = s_data[0];
            col_d   = '0;
            state_d = S_COLLECT;
          end else begin
            case (s_data[7:6])
              2'b00: begin
                issue   = 1'b1;
                new_pix = idx_rd;
              end
              2'b01: begin
                issue   = 1'b1;
                new_pix = {prev_q[31:24],
                           prev_q[23:16] + {6'b0, s_data[1:0]} - 8'd2,
                           prev_q[15:8]  + {6'b0, s_data[3:2]} - 8'd2,
                           prev_q[7:0]   + {6'b0, s_data[5:4]} - 8'd2};
              end
              2'b10: begin
                dg_d    = {2'b0, s_data[5:0]} - 8'd32;
                state_d = S_LUMA2;
              end
              default: begin
                // First run pixel goes out with the tag; RUN emits the remaining count.
                issue   = 1'b1;
                new_pix = prev_q;
                run_d   = s_data[5:0];
                if (s_data[5:0] != '0) state_d = S_RUN;
              end
            endcase
          end
        end
      end
      S_COLLECT: begin
        if (acc) begin
          col_d = col_q + 2'd1;
          case (col_q)
            2'd0:    buf_d[7:0]   = s_data;
            2'd1:    buf_d[15:8]  = s_data;
            default: buf_d[23:16] = s_data;
          endcase
          if (!rgba_q && col_q == 2'd2) begin
            issue   = 1'b1;
            new_pix = {prev_q[31:24], s_data, buf_q[15:0]};
            state_d = S_OP;
          end else if (rgba_q && col_q == 2'd3) begin
            issue   = 1'b1;
            new_pix = {s_data, buf_q};
            state_d = S_OP;
          end
        end
      end
      S_LUMA2: begin
        if (acc) begin
          nr      = prev_q[7:0]   + dg_q - 8'd8 + {4'b0, s_data[7:4]};
          ng      = prev_q[15:8]  + dg_q;
          nb      = prev_q[23:16] + dg_q - 8'd8 + {4'b0, s_data[3:0]};
          issue   = 1'b1;
          new_pix = {prev_q[31:24], nb, ng, nr};
          state_d = S_OP;
        end
      end
      S_RUN: begin
        if (can_issue) begin
          issue   = 1'b1;
          new_pix = prev_q;
          run_d   = run_q - 6'd1;
          if (run_q == 6'd1) state_d = S_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    emit_pix = new_pix;
    if (CHANNELS == 3) emit_pix[31:24] = ALPHA_DEF;
    wr_idx = hash6(emit_pix);

    if (issue) begin
      mval_d        = 1'b1;
      pix_d         = emit_pix;
      prev_d        = emit_pix;
      vld_d[wr_idx] = 1'b1;
    end

    // Last handshake ends the frame; any unfinished run is an overshoot.
    if (hs && cnt_q == SIZE_W'(1)) begin
      state_d = S_DONE;
      if (state_q == S_RUN && run_q != '0) err_d = 1'b1;
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      pix_q   <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      run_q   <= '0;
      col_q   <= '0;
      rgba_q  <= 1'b0;
      buf_q   <= '0;
      dg_q    <= '0;
      mval_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      col_q   <= col_d;
      rgba_q  <= rgba_d;
      buf_q   <= buf_d;
      dg_q    <= dg_d;
      mval_q  <= mval_d;
      err_q   <= err_d;
    end
  end

  // Index storage needs no reset: the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (issue) mem[wr_idx] <= emit_pix;
  end

  assign m_pixel = pix_q;
  assign m_valid = mval_q;
  assign o_busy  = (state_q == S_OP) || (state_q == S_COLLECT) ||
                   (state_q == S_LUMA2) || (state_q == S_RUN);
  assign o_done  = (state_q == S_DONE);
  assign o_err   = err_q;

endmodule

// File: tb/tb_qoi_chunk_decoder.sv
module tb_qoi_chunk_decoder;
  localparam int unsigned SW = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [SW-1:0] i_npix = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b1;
  logic          s_ready, m_valid, o_busy, o_done, o_err;
  logic [31:0]   m_pixel;
  logic          s_ready3, m_valid3, o_busy3, o_done3, o_err3;
  logic [31:0]   m_pixel3;

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  bit toggle_mode = 1'b0;
  bit chk3 = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp3_q[$];

  qoi_chunk_decoder #(.SIZE_W(SW), .CHANNELS(4), .ALPHA_DEF(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_npix(i_npix),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_ready(m_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

  qoi_chunk_decoder #(.SIZE_W(SW), .CHANNELS(3), .ALPHA_DEF(8'hFF)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_npix(i_npix),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready3),
    .m_pixel(m_pixel3), .m_valid(m_valid3), .m_ready(m_ready),
    .o_busy(o_busy3), .o_done(o_done3), .o_err(o_err3));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every presented pixel is compared with the queue head,
  // popped only on handshake, so a stalled pixel is re-checked each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) acc_cnt++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pixel: got %h, expected no pixel", m_pixel);
        end else begin
          check("pixel", m_pixel, exp_q[0]);
          if (m_ready) void'(exp_q.pop_front());
        end
      end
      if (chk3 && m_valid3) begin
        if (exp3_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pixel3: got %h, expected no pixel", m_pixel3);
        end else begin
          check("pixel3", m_pixel3, exp3_q[0]);
          if (m_ready) void'(exp3_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_mode) m_ready = ~m_ready;
    else             m_ready = 1'b1;
  end

  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    s_data = b;
    s_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #2;
      end
    end
    s_valid = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL byte_accept: byte %h not accepted, expected acceptance within 200 cycles", b);
    end
  endtask

  task automatic start(input int n);
    @(posedge clk); #2;
    i_start = 1'b1;
    i_npix = SW'(n);
    @(posedge clk); #2;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!o_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(o_done), 32'd1);
    check({name, "_busy"}, 32'(o_busy), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_pixel", m_pixel, 32'h0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // RGB chunk; a start pulse mid-frame must be ignored
    acc_cnt = 0;
    exp_q.push_back(32'hFF302010);
    start(1);
    check("t1_busy", 32'(o_busy), 32'd1);
    push_byte(8'hFE);
    start(5);
    push_byte(8'h10);
    push_byte(8'h20);
    push_byte(8'h30);
    wait_done("t1");
    check("t1_bytes", 32'(acc_cnt), 32'd4);
    check("t1_err", 32'(o_err), 32'd0);

    // End marker bytes are not consumed once done
    s_data = 8'h00;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_no_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    check("done_bytes", 32'(acc_cnt), 32'd4);

    // DIFF then short run
    acc_cnt = 0;
    repeat (3) exp_q.push_back(32'hFF010101);
    start(3);
    push_byte(8'h7F);
    push_byte(8'hC1);
    wait_done("t2");
    check("t2_bytes", 32'(acc_cnt), 32'd2);

    // RGBA, INDEX hit on hash 14, INDEX miss on 53
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h00000000);
    start(3);
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'h02);
    push_byte(8'h03); push_byte(8'h04);
    push_byte(8'h0E);
    push_byte(8'h35);
    wait_done("t3");

    // Run overshoot with a stalling sink
    acc_cnt = 0;
    toggle_mode = 1'b1;
    repeat (2) exp_q.push_back(32'hFF000000);
    start(2);
    push_byte(8'hC9);
    wait_done("t5");
    toggle_mode = 1'b0;
    check("t5_err", 32'(o_err), 32'd1);
    check("t5_bytes", 32'(acc_cnt), 32'd1);

    // LUMA then DIFF from the LUMA result; start clears o_err
    exp_q.push_back(32'hFF080808);
    exp_q.push_back(32'hFF060606);
    start(2);
    check("t4_err_cleared", 32'(o_err), 32'd0);
    push_byte(8'hA8);
    push_byte(8'h88);
    push_byte(8'h40);
    wait_done("t4");

    // DIFF -2 from freshly reset prev
    exp_q.push_back(32'hFFFEFEFE);
    start(1);
    push_byte(8'h40);
    wait_done("t4b");

    // Zero-pixel frame
    start(0);
    @(negedge clk);
    check("npix0_done", 32'(o_done), 32'd1);
    check("npix0_ready", 32'(s_ready), 32'd0);

    // Three-channel instance: alpha forced, hash uses forced alpha (23)
    chk3 = 1'b1;
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h00000000);
    exp3_q.push_back(32'hFF030201);
    exp3_q.push_back(32'hFF030201);
    start(2);
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'h02);
    push_byte(8'h03); push_byte(8'h04);
    push_byte(8'h17);
    wait_done("ch3");
    check("ch3_done3", 32'(o_done3), 32'd1);
    check("ch3_drained3", 32'(exp3_q.size()), 32'd0);
    chk3 = 1'b0;

    // Reset in the middle of an RGB chunk
    start(1);
    push_byte(8'hFF);
    push_byte(8'h01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_ready", 32'(s_ready), 32'd0);
    check("midrst_busy3", 32'(o_busy3), 32'd0);
    check("midrst_err3", 32'(o_err3), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_done", 32'(o_done), 32'd0);
    check("midrst_idle_valid", 32'(m_valid | m_valid3 | s_ready3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
